// File: rtl/pipe_ctrl.sv
// Pipeline hazard, flush and halt controller for a five-stage in-order core.
// Optional feature: define FORWARDING_EN to enable the M/W bypass network (load-use stalls only).
module pipe_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs1_d,
    input  logic [4:0]  rs2_d,
    input  logic        use_rs1_d,
    input  logic        use_rs2_d,
    input  logic        pause_d,
    input  logic        jump_e,
    input  logic [4:0]  rs1_e,
    input  logic [4:0]  rs2_e,
    input  logic [4:0]  rd_e,
    input  logic        writesreg_e,
    input  logic        memtoreg_e,
    input  logic [4:0]  rd_m,
    input  logic [4:0]  rd_w,
    input  logic        writesreg_m,
    input  logic        writesreg_w,
    input  logic        mem_busy,
    input  logic        resume,
    output logic        stall_f,
    output logic        stall_d,
    output logic        stall_e,
    output logic        stall_m,
    output logic        flush_d,
    output logic        flush_e,
    output logic [1:0]  fwd_a_e,
    output logic [1:0]  fwd_b_e,
    output logic        halted,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [1:0]  drain_cnt_r;
    logic [1:0]  next_drain_cnt_s;
    logic        halted_r;
    logic [15:0] stall_cnt_r;

    logic        hazard_s;
    logic [1:0]  fwd_a_s;
    logic [1:0]  fwd_b_s;
    logic        stall_f_s;
    logic        stall_d_s;
    logic        stall_e_s;
    logic        stall_m_s;
    logic        flush_d_s;
    logic        flush_e_s;

    // A producer only matches when it really writes a register other than x0.
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst,
                                       input logic wr);
        reg_match = wr && (dst != 5'd0) && (src == dst);
    endfunction

`ifdef FORWARDING_EN
    // M is the younger producer, so it wins over W.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (reg_match(src, rd_m, writesreg_m)) begin
            fwd_sel = 2'b10;
        end else if (reg_match(src, rd_w, writesreg_w)) begin
            fwd_sel = 2'b01;
        end else begin
            fwd_sel = 2'b00;
        end
    endfunction

    // Bypass covers everything except a load whose data is not yet available.
    always_comb begin
        hazard_s = memtoreg_e &&
                   ((use_rs1_d && reg_match(rs1_d, rd_e, writesreg_e)) ||
                    (use_rs2_d && reg_match(rs2_d, rd_e, writesreg_e)));
        fwd_a_s  = fwd_sel(rs1_e);
        fwd_b_s  = fwd_sel(rs2_e);
    end
`else
    // Without bypass, any in-flight writer of a used source must retire first.
    always_comb begin
        hazard_s = (use_rs1_d && (reg_match(rs1_d, rd_e, writesreg_e) ||
                                  reg_match(rs1_d, rd_m, writesreg_m) ||
                                  reg_match(rs1_d, rd_w, writesreg_w))) ||
                   (use_rs2_d && (reg_match(rs2_d, rd_e, writesreg_e) ||
                                  reg_match(rs2_d, rd_m, writesreg_m) ||
                                  reg_match(rs2_d, rd_w, writesreg_w)));
        fwd_a_s  = 2'b00;
        fwd_b_s  = 2'b00;
    end
`endif

    // Next-state and stall/flush decode with mem_busy > jump > hazard > pause.
    always_comb begin
        next_state_s     = state_r;
        next_drain_cnt_s = drain_cnt_r;
        stall_f_s        = 1'b0;
        stall_d_s        = 1'b0;
        stall_e_s        = 1'b0;
        stall_m_s        = 1'b0;
        flush_d_s        = 1'b0;
        flush_e_s        = 1'b0;
        if (mem_busy) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            stall_e_s = 1'b1;
            stall_m_s = 1'b1;
        end else begin
            case (state_r)
                RUN: begin
                    if (jump_e) begin
                        flush_d_s = 1'b1;
                        flush_e_s = 1'b1;
                    end else if (hazard_s) begin
                        stall_f_s = 1'b1;
                        stall_d_s = 1'b1;
                        flush_e_s = 1'b1;
                    end else if (pause_d) begin
                        stall_f_s        = 1'b1;
                        stall_d_s        = 1'b1;
                        flush_e_s        = 1'b1;
                        next_state_s     = DRAIN;
                        next_drain_cnt_s = 2'd3;
                    end else begin
                        next_state_s = RUN;
                    end
                end
                DRAIN: begin
                    stall_f_s        = 1'b1;
                    stall_d_s        = 1'b1;
                    flush_e_s        = 1'b1;
                    next_drain_cnt_s = drain_cnt_r - 2'd1;
                    // A corrupted zero count also ends the drain instead of wrapping.
                    if (drain_cnt_r <= 2'd1) begin
                        next_state_s = HALT;
                    end else begin
                        next_state_s = DRAIN;
                    end
                end
                HALT: begin
                    if (resume) begin
                        flush_d_s    = 1'b1;
                        next_state_s = RUN;
                    end else begin
                        stall_f_s = 1'b1;
                        stall_d_s = 1'b1;
                        flush_e_s = 1'b1;
                    end
                end
                default: begin
                    next_state_s     = RUN;
                    next_drain_cnt_s = 2'd0;
                end
            endcase
        end
    end

    // Pipeline controls are forced inactive while reset is held.
    always_comb begin
        if (reset) begin
            stall_f = 1'b0;
            stall_d = 1'b0;
            stall_e = 1'b0;
            stall_m = 1'b0;
            flush_d = 1'b0;
            flush_e = 1'b0;
            fwd_a_e = 2'b00;
            fwd_b_e = 2'b00;
        end else begin
            stall_f = stall_f_s;
            stall_d = stall_d_s;
            stall_e = stall_e_s;
            stall_m = stall_m_s;
            flush_d = flush_d_s;
            flush_e = flush_e_s;
            fwd_a_e = fwd_a_s;
            fwd_b_e = fwd_b_s;
        end
    end

    // State, drain counter, halt flag and saturating stall counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= RUN;
            drain_cnt_r <= 2'd0;
            halted_r    <= 1'b0;
            stall_cnt_r <= 16'd0;
        end else begin
            state_r     <= next_state_s;
            drain_cnt_r <= next_drain_cnt_s;
            halted_r    <= (next_state_s == HALT);
            if (stall_d_s && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign halted    = halted_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table plus multi-cycle drain/halt sequences,
// expectations queued at drive time and popped when outputs are sampled.
module tb_pipe_ctrl;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e}
    localparam logic [5:0] NOST = 6'b000000;
    localparam logic [5:0] HZ   = 6'b110001;
    localparam logic [5:0] BUSY = 6'b111100;
    localparam logic [5:0] JMP  = 6'b000011;
    localparam logic [5:0] RES  = 6'b000010;

    typedef struct {
        logic [4:0] rs1_d, rs2_d;
        logic       u1, u2;
        logic [4:0] rs1_e, rs2_e, rd_e;
        logic       we, mt;
        logic [4:0] rd_m;
        logic       wm;
        logic [4:0] rd_w;
        logic       ww;
        logic       jump, pause, busy, res, rst;
        logic [5:0] ex;
        logic [1:0] fa, fb;
        logic       hl;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic        use_rs1_d, use_rs2_d, pause_d, jump_e;
    logic        writesreg_e, memtoreg_e, writesreg_m, writesreg_w, mem_busy, resume;
    logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, halted;
    logic [1:0]  fwd_a_e, fwd_b_e;
    logic [15:0] stall_cnt;

    int          n_cmp;
    int          n_bad;
    int          step;
    logic [15:0] exp_cnt;
    vec_t        sb[$];
    vec_t        tbl[18];

    pipe_ctrl dut (
        .clk(clk), .reset(reset),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
        .pause_d(pause_d), .jump_e(jump_e),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .writesreg_e(writesreg_e), .memtoreg_e(memtoreg_e),
        .rd_m(rd_m), .rd_w(rd_w), .writesreg_m(writesreg_m), .writesreg_w(writesreg_w),
        .mem_busy(mem_busy), .resume(resume),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .halted(halted), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkv(input int a1d, input int a2d, input int u1, input int u2,
                                 input int a1e, input int a2e, input int rde, input int we,
                                 input int mt, input int rdm, input int wm, input int rdw,
                                 input int ww, input int jmp, input int pau, input int bsy,
                                 input logic [5:0] ex, input logic [1:0] fa, input logic [1:0] fb);
        vec_t v;
        v.rs1_d = 5'(a1d); v.rs2_d = 5'(a2d); v.u1 = 1'(u1); v.u2 = 1'(u2);
        v.rs1_e = 5'(a1e); v.rs2_e = 5'(a2e); v.rd_e = 5'(rde);
        v.we = 1'(we); v.mt = 1'(mt);
        v.rd_m = 5'(rdm); v.wm = 1'(wm); v.rd_w = 5'(rdw); v.ww = 1'(ww);
        v.jump = 1'(jmp); v.pause = 1'(pau); v.busy = 1'(bsy);
        v.res = 1'b0; v.rst = 1'b0;
        v.ex = ex; v.fa = fa; v.fb = fb; v.hl = 1'b0;
        return v;
    endfunction

    function automatic vec_t ctl(input int jmp, input int pau, input int bsy, input int rsm,
                                 input int rst, input logic [5:0] ex, input int hl);
        vec_t v;
        v = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, jmp, pau, bsy, ex, 2'b00, 2'b00);
        v.res = 1'(rsm);
        v.rst = 1'(rst);
        v.hl  = 1'(hl);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, step, act, expv);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        reset = v.rst; rs1_d = v.rs1_d; rs2_d = v.rs2_d; use_rs1_d = v.u1; use_rs2_d = v.u2;
        rs1_e = v.rs1_e; rs2_e = v.rs2_e; rd_e = v.rd_e; writesreg_e = v.we; memtoreg_e = v.mt;
        rd_m = v.rd_m; writesreg_m = v.wm; rd_w = v.rd_w; writesreg_w = v.ww;
        jump_e = v.jump; pause_d = v.pause; mem_busy = v.busy; resume = v.res;
        sb.push_back(v);
        #2;
        e = sb.pop_front();
        chk("stall_f", {15'd0, stall_f}, {15'd0, e.ex[5]});
        chk("stall_d", {15'd0, stall_d}, {15'd0, e.ex[4]});
        chk("stall_e", {15'd0, stall_e}, {15'd0, e.ex[3]});
        chk("stall_m", {15'd0, stall_m}, {15'd0, e.ex[2]});
        chk("flush_d", {15'd0, flush_d}, {15'd0, e.ex[1]});
        chk("flush_e", {15'd0, flush_e}, {15'd0, e.ex[0]});
        chk("fwd_a_e", {14'd0, fwd_a_e}, {14'd0, e.fa});
        chk("fwd_b_e", {14'd0, fwd_b_e}, {14'd0, e.fb});
        chk("halted", {15'd0, halted}, {15'd0, e.hl});
        chk("stall_cnt", stall_cnt, exp_cnt);
        if (e.rst) begin
            exp_cnt = 16'd0;
        end else if (e.ex[4] && (exp_cnt != 16'hFFFF)) begin
            exp_cnt = exp_cnt + 16'd1;
        end
        step++;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; step = 0; exp_cnt = 16'd0;
        reset = 1'b1; rs1_d = 5'd0; rs2_d = 5'd0; use_rs1_d = 1'b0; use_rs2_d = 1'b0;
        rs1_e = 5'd0; rs2_e = 5'd0; rd_e = 5'd0; writesreg_e = 1'b0; memtoreg_e = 1'b0;
        rd_m = 5'd0; rd_w = 5'd0; writesreg_m = 1'b0; writesreg_w = 1'b0;
        jump_e = 1'b0; pause_d = 1'b0; mem_busy = 1'b0; resume = 1'b0;

        tbl[0]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NOST, 2'b00, 2'b00);
        tbl[1]  = mkv(5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, HZ, 2'b00, 2'b00);
        tbl[2]  = mkv(5, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, NOST, 2'b00, 2'b00);
        tbl[3]  = mkv(0, 6, 0, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, FWD ? NOST : HZ, 2'b00, 2'b00);
        tbl[4]  = mkv(0, 0, 1, 0, 7, 0, 0, 1, 1, 7, 1, 7, 1, 0, 0, 0, NOST, FWD ? 2'b10 : 2'b00, 2'b00);
        tbl[5]  = mkv(0, 0, 0, 0, 0, 9, 0, 0, 0, 0, 0, 9, 1, 0, 0, 0, NOST, 2'b00, FWD ? 2'b01 : 2'b00);
        tbl[6]  = mkv(0, 0, 0, 0, 3, 0, 0, 0, 0, 3, 0, 3, 1, 0, 0, 0, NOST, FWD ? 2'b01 : 2'b00, 2'b00);
        tbl[7]  = mkv(4, 0, 1, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, FWD ? NOST : HZ, 2'b00, 2'b00);
        tbl[8]  = mkv(0, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8, 1, 0, 0, 0, FWD ? NOST : HZ, 2'b00, 2'b00);
        tbl[9]  = mkv(0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0, 0, 0, NOST, 2'b00, 2'b00);
        tbl[10] = mkv(5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 1, 1, 0, JMP, 2'b00, 2'b00);
        tbl[11] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NOST, 2'b00, 2'b00);
        tbl[12] = mkv(5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 1, 1, 1, BUSY, 2'b00, 2'b00);
        tbl[13] = mkv(5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 1, 0, HZ, 2'b00, 2'b00);
        tbl[14] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NOST, 2'b00, 2'b00);
        tbl[15] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, BUSY, 2'b00, 2'b00);
        tbl[16] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NOST, 2'b00, 2'b00);
        tbl[17] = mkv(0, 0, 0, 0, 12, 12, 0, 0, 0, 12, 1, 12, 1, 0, 0, 0, NOST,
                      FWD ? 2'b10 : 2'b00, FWD ? 2'b10 : 2'b00);

        // Two reset edges with nothing checked, then the reset state itself.
        repeat (2) @(posedge clk);
        apply(ctl(0, 0, 0, 0, 1, NOST, 0));

        for (int i = 0; i < 18; i++) begin
            apply(tbl[i]);
        end

        // Load-use stall, then the load has moved to M and the consumer is in E.
        apply(mkv(5, 0, 1, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, HZ, 2'b00, 2'b00));
        apply(mkv(0, 0, 0, 0, 5, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, NOST, FWD ? 2'b10 : 2'b00, 2'b00));

        // Pause: three drain cycles, halt, ignored resume/jump, resume pulse.
        apply(ctl(0, 1, 0, 0, 0, HZ, 0));
        apply(ctl(0, 0, 0, 1, 0, HZ, 0));
        apply(ctl(0, 0, 0, 0, 0, HZ, 0));
        apply(ctl(0, 0, 0, 0, 0, HZ, 0));
        apply(ctl(0, 0, 0, 0, 0, HZ, 1));
        apply(ctl(1, 0, 0, 0, 0, HZ, 1));
        apply(ctl(0, 0, 0, 1, 0, RES, 1));
        apply(ctl(0, 0, 0, 0, 0, NOST, 0));
        apply(ctl(0, 0, 0, 0, 0, NOST, 0));

        // Pause with a two-cycle memory stall in the middle of the drain.
        apply(ctl(0, 1, 0, 0, 0, HZ, 0));
        apply(ctl(0, 0, 0, 0, 0, HZ, 0));
        apply(ctl(0, 0, 1, 0, 0, BUSY, 0));
        apply(ctl(0, 0, 1, 0, 0, BUSY, 0));
        apply(ctl(0, 0, 0, 0, 0, HZ, 0));
        apply(ctl(0, 0, 0, 0, 0, HZ, 0));
        apply(ctl(0, 0, 0, 0, 0, HZ, 1));
        apply(ctl(0, 0, 1, 1, 0, BUSY, 1));
        apply(ctl(0, 0, 0, 0, 0, HZ, 1));

        // Sit in HALT until the stall counter saturates.
        for (int i = 0; i < 65540; i++) begin
            apply(ctl(0, 0, 0, 0, 0, HZ, 1));
        end
        chk("stall_cnt_sat_model", exp_cnt, 16'hFFFF);
        apply(ctl(0, 0, 0, 0, 0, HZ, 1));

        // Reset while halted returns to RUN with a cleared counter.
        apply(ctl(0, 0, 0, 0, 1, NOST, 1));
        apply(ctl(0, 0, 0, 0, 0, NOST, 0));
        apply(ctl(0, 1, 0, 0, 0, HZ, 0));
        apply(ctl(0, 0, 0, 0, 0, HZ, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk input 1 (sole clock, rising edge); reset input 1 (synchronous, active-high).
REQ-002 SHALL have: rs1_d, rs2_d input 5 (D-stage source regs); use_rs1_d, use_rs2_d input 1 (source actually read).
REQ-003 SHALL have: pause_d input 1 (decoder pause flag for D-stage instr); jump_e input 1 (taken jump resolved in E).
REQ-004 SHALL have: rs1_e, rs2_e, rd_e input 5; writesreg_e, memtoreg_e input 1 (E-stage instr info).
REQ-005 SHALL have: rd_m, rd_w input 5; writesreg_m, writesreg_w input 1; mem_busy input 1 (data memory not ready, M stage).
REQ-006 SHALL have: resume input 1 (external release from halt).
REQ-007 SHALL have: stall_f, stall_d, stall_e, stall_m output 1; flush_d, flush_e output 1 (insert bubble).
REQ-008 SHALL have: fwd_a_e, fwd_b_e output 2 (00 regfile, 10 from M, 01 from W); halted output 1; stall_cnt output 16.

Function
REQ-009 SHALL implement FSM states RUN, DRAIN, HALT; hazard/forward logic combinational, FSM and counters registered.
REQ-010 Register match SHALL require writesreg of producer set and rd != 0; x0 never matches.
REQ-011 Priority SHALL be: mem_busy > jump_e > data hazard > pause_d.
REQ-012 mem_busy=1 SHALL assert stall_f/d/e/m, deassert both flushes, freeze FSM and drain counter.
REQ-013 jump_e=1 (no mem_busy) SHALL assert flush_d and flush_e for one cycle, no stalls; pause_d that cycle ignored.
REQ-014 Data hazard SHALL assert stall_f, stall_d, flush_e in the same cycle; stall_e/stall_m stay 0.
REQ-015 pause_d in RUN with no higher-priority event SHALL assert stall_f, stall_d, flush_e, enter DRAIN, load 2-bit drain counter with 3.
REQ-016 DRAIN SHALL hold stall_f, stall_d, flush_e high and decrement counter each non-busy cycle; at counter 1 the next state is HALT.
REQ-017 HALT SHALL assert halted=1, stall_f, stall_d, flush_e; resume=1 SHALL return to RUN and pulse flush_d one cycle (pause instr retired, not re-decoded).
REQ-018 resume outside HALT SHALL be ignored; jump_e in DRAIN/HALT is impossible (E flushed) and SHALL not change state.
REQ-019 stall_cnt SHALL increment in every cycle stall_d=1, saturating at 16'hFFFF (no wrap).
REQ-020 Forwarding select SHALL prefer M over W when both match the same source.

Reset
REQ-021 reset=1 at a clock edge SHALL set state RUN, drain counter 0, stall_cnt 0, halted 0, overriding any in-progress DRAIN/HALT.
REQ-022 While reset=1 all stall and flush outputs SHALL be 0 and fwd selects 00.

Configuration
REQ-023 Macro FORWARDING_EN SHALL select the forwarding feature.
REQ-024 With FORWARDING_EN: fwd_a_e/fwd_b_e driven per REQ-020 from rs1_e/rs2_e; data hazard = load-use only (memtoreg_e and rd_e matches a used D source).
REQ-025 Without FORWARDING_EN: fwd outputs constant 00; data hazard = any used D source matching a writing rd_e, rd_m or rd_w.

Verification
REQ-026 Load x5 in E (memtoreg_e=1), D reads x5 -> one cycle stall_f=stall_d=flush_e=1; with FORWARDING_EN next cycle fwd_a_e=10.
REQ-027 rd_m=rd_w=7 both writing, rs1_e=7 -> fwd_a_e=10; rd_e=0 writesreg_e=1, rs1_d=0 -> no stall.
REQ-028 pause_d=1 in RUN -> DRAIN 3 cycles, HALT with halted=1; resume=1 -> RUN, flush_d=1 one cycle, halted=0.
REQ-029 mem_busy=1 for 2 cycles mid-DRAIN -> all four stalls high, drain counter frozen, HALT reached 2 cycles later than REQ-028.
REQ-030 jump_e=1 with pause_d=1 same cycle -> flush_d=flush_e=1, state stays RUN; reset asserted in HALT -> RUN, stall_cnt=0 next cycle.
